bin_to_bcd_hs: RTL and testbench

Parametrised, handshaked binary-to-BCD converter: the next generation of the team's fixed 16-bit/4-digit converter. It accepts a `BIN_W`-bit unsigned value over a valid/ready input channel and runs a shift-and-add-3 (double dabble) loop, one bit per cycle. It returns a `DIGITS`-digit packed BCD result, or an error pattern with an overflow flag, over a valid/ready output channel. It sits between measurement/arithmetic blocks and the seven-segment display path. Unlike its predecessor, it signals result validity explicitly and does not restart on input changes.

---
 rtl/bin_to_bcd_hs.sv | 120 ++++++++++++
 tb/tb_bin_to_bcd_hs.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_hs.sv
// Handshaked binary-to-BCD converter using a one-bit-per-cycle double dabble loop.
// Inputs whose value is above the largest representable decimal return an error pattern with overflow set.
module bin_to_bcd_hs #(
    parameter int         BIN_W      = 16,
    parameter int         DIGITS     = 4,
    parameter logic [3:0] ERR_NIBBLE = 4'hE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic                  busy
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SCR_W = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int MAX_W = (BIN_W + 1 > 32) ? (BIN_W + 1) : 32;

    function automatic logic [MAX_W-1:0] calc_max(input int digits);
        logic [MAX_W-1:0] p;
        p = MAX_W'(1);
        for (int i = 0; i < digits; i++) begin
            p = p * MAX_W'(10);
        end
        return p - MAX_W'(1);
    endfunction

    // Conditional add-3 on every digit, all evaluated from the same pre-shift value.
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] d);
        logic [BCD_W-1:0] r;
        r = d;
        for (int i = 0; i < DIGITS; i++) begin
            if (d[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = d[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = d[4*i +: 4];
            end
        end
        return r;
    endfunction

    localparam logic [MAX_W-1:0] MAX_VAL     = calc_max(DIGITS);
    localparam logic [BCD_W-1:0] ERR_PATTERN = {DIGITS{ERR_NIBBLE}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_r;
    logic [SCR_W-1:0]   scratch_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [SCR_W-1:0]   shifted_s;
    logic [BCD_W-1:0]   digits_s;
    logic [MAX_W-1:0]   bin_ext_s;

    // Next scratch value for one double dabble iteration and widened input for the range test.
    always_comb begin
        bin_ext_s = MAX_W'(bin_in);
        digits_s  = add3_digits(scratch_r[SCR_W-1:BIN_W]);
        shifted_s = {digits_s, scratch_r[BIN_W-1:0]} << 1'b1;
    end

    // Control FSM, scratch/counter datapath and registered result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            scratch_r <= '0;
            cnt_r     <= '0;
            bcd_out   <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        if (bin_ext_s > MAX_VAL) begin
                            bcd_out  <= ERR_PATTERN;
                            overflow <= 1'b1;
                            state_r  <= DONE;
                        end else begin
                            scratch_r <= {{BCD_W{1'b0}}, bin_in};
                            cnt_r     <= CNT_W'(BIN_W);
                            overflow  <= 1'b0;
                            state_r   <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    scratch_r <= shifted_s;
                    cnt_r     <= cnt_r - CNT_W'(1);
                    // Only the final post-shift digit field ever reaches bcd_out.
                    if (cnt_r == CNT_W'(1)) begin
                        bcd_out <= shifted_s[SCR_W-1:BIN_W];
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_bin_to_bcd_hs.sv
// Bench for bin_to_bcd_hs: three configurations checked every cycle against an arithmetic
// timeline model, plus directed vectors with hand-computed results.
module tb_bin_to_bcd_hs;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] bin_v;
    int          sel;
    bit          started;
    int          checks;
    int          errors;

    logic [2:0]  in_ready_a;
    logic [2:0]  out_valid_a;
    logic [2:0]  busy_a;
    logic [2:0]  ovf_a;
    logic [35:0] bcd_a [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [35:0] to_bcd(input longint v, input int dg);
        logic [35:0] r = '0;
        longint x = v;
        for (int i = 0; i < dg; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic longint max_val(input int dg);
        longint p = 1;
        for (int i = 0; i < dg; i++) p = p * 10;
        return p - 1;
    endfunction

    function automatic logic [35:0] err_pat(input int dg);
        logic [35:0] r = '0;
        for (int i = 0; i < dg; i++) r[4*i +: 4] = 4'hE;
        return r;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int BW = (g == 0) ? 16 : (g == 1) ? 20 : 8;
        localparam int DG = (g == 0) ? 4 : (g == 1) ? 6 : 3;

        logic [BW-1:0]   bin_g;
        logic            iv_g;
        logic            ir_g;
        logic            ov_g;
        logic            busy_g;
        logic            ovf_g;
        logic [4*DG-1:0] bcd_g;

        assign bin_g = bin_v[BW-1:0];
        assign iv_g  = in_valid && (sel == g);

        bin_to_bcd_hs #(.BIN_W(BW), .DIGITS(DG), .ERR_NIBBLE(4'hE)) dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (iv_g),
            .in_ready  (ir_g),
            .bin_in    (bin_g),
            .out_valid (ov_g),
            .out_ready (out_ready),
            .bcd_out   (bcd_g),
            .overflow  (ovf_g),
            .busy      (busy_g)
        );

        assign in_ready_a[g]  = ir_g;
        assign out_valid_a[g] = ov_g;
        assign busy_a[g]      = busy_g;
        assign ovf_a[g]       = ovf_g;
        assign bcd_a[g]       = 36'(bcd_g);

        // Model: 0 = idle, 1 = converting (m_wait edges left), 2 = result offered
        int          m_st   = 0;
        int          m_wait = 0;
        logic [35:0] m_bcd  = '0;
        logic [35:0] m_pend = '0;
        logic        m_ovf  = 1'b0;

        always @(posedge clk) begin
            if (reset) begin
                m_st   <= 0;
                m_wait <= 0;
                m_bcd  <= '0;
                m_ovf  <= 1'b0;
            end else if (m_st == 0) begin
                if (iv_g) begin
                    if (longint'(bin_g) > max_val(DG)) begin
                        m_st  <= 2;
                        m_bcd <= err_pat(DG);
                        m_ovf <= 1'b1;
                    end else begin
                        m_st   <= 1;
                        m_wait <= BW;
                        m_pend <= to_bcd(longint'(bin_g), DG);
                        m_ovf  <= 1'b0;
                    end
                end
            end else if (m_st == 1) begin
                m_wait <= m_wait - 1;
                if (m_wait == 1) begin
                    m_st  <= 2;
                    m_bcd <= m_pend;
                end
            end else if (out_ready) begin
                m_st <= 0;
            end
        end

        always @(negedge clk) begin
            if (started) begin
                check("model_in_ready",  64'(ir_g),      64'(m_st == 0));
                check("model_out_valid", 64'(ov_g),      64'(m_st == 2));
                check("model_busy",      64'(busy_g),    64'(m_st != 0));
                check("model_bcd",       64'(bcd_a[g]),  64'(m_bcd));
                check("model_overflow",  64'(ovf_g),     64'(m_ovf));
            end
        end
    end

    task automatic run(input int g, input longint v, input logic [35:0] exp_bcd,
                       input bit exp_ovf, input int exp_edge, input int hold, input bit churn);
        int w;
        int k;
        @(negedge clk);
        w = 0;
        while (!in_ready_a[g] && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("accept_ready", 64'(in_ready_a[g]), 64'(1));
        sel       = g;
        bin_v     = 32'(v);
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid_a[g] && k < 100) begin
            if (churn) begin
                in_valid = ~in_valid;
                bin_v    = $urandom;
            end
            @(negedge clk);
            k++;
        end
        in_valid = 1'b0;
        check("latency_edges", 64'(k), 64'(exp_edge));
        check("bcd_literal", 64'(bcd_a[g]), 64'(exp_bcd));
        check("ovf_literal", 64'(ovf_a[g]), 64'(exp_ovf));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_out_valid", 64'(out_valid_a[g]), 64'(1));
            check("hold_in_ready",  64'(in_ready_a[g]),  64'(0));
            check("hold_bcd",       64'(bcd_a[g]),       64'(exp_bcd));
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("idle_after_in_ready",  64'(in_ready_a[g]),  64'(1));
        check("idle_after_out_valid", 64'(out_valid_a[g]), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        started   = 1'b0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        bin_v     = 32'd0;
        sel       = 0;
        @(negedge clk);
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check("reset_in_ready",  64'(in_ready_a[g]),  64'(1));
            check("reset_out_valid", 64'(out_valid_a[g]), 64'(0));
            check("reset_busy",      64'(busy_a[g]),      64'(0));
            check("reset_bcd",       64'(bcd_a[g]),       64'(0));
            check("reset_overflow",  64'(ovf_a[g]),       64'(0));
        end
        started = 1'b1;
        reset   = 1'b0;

        run(0, 9999,  36'h9999, 1'b0, 16, 0, 1'b0);
        run(0, 0,     36'h0000, 1'b0, 16, 0, 1'b0);
        run(0, 1234,  36'h1234, 1'b0, 16, 0, 1'b0);
        run(0, 10000, 36'hEEEE, 1'b1, 0,  0, 1'b0);
        run(0, 65535, 36'hEEEE, 1'b1, 0,  0, 1'b0);
        run(0, 5,     36'h0005, 1'b0, 16, 0, 1'b0);
        run(0, 4095,  36'h4095, 1'b0, 16, 5, 1'b0);
        run(0, 42,    36'h0042, 1'b0, 16, 0, 1'b1);

        // Abort a conversion of 8888 part-way through with a one-cycle reset.
        @(negedge clk);
        sel      = 0;
        bin_v    = 32'd8888;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_shift_busy", 64'(busy_a[0]), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_in_ready",  64'(in_ready_a[0]),  64'(1));
        check("abort_out_valid", 64'(out_valid_a[0]), 64'(0));
        check("abort_busy",      64'(busy_a[0]),      64'(0));
        check("abort_bcd",       64'(bcd_a[0]),       64'(0));
        check("abort_overflow",  64'(ovf_a[0]),       64'(0));
        run(0, 7, 36'h0007, 1'b0, 16, 0, 1'b0);

        run(1, 999999,  36'h999999, 1'b0, 20, 0, 1'b0);
        run(1, 1000000, 36'hEEEEEE, 1'b1, 0,  0, 1'b0);
        run(2, 255,     36'h255,    1'b0, 8,  0, 1'b0);
        run(2, 100,     36'h100,    1'b0, 8,  0, 1'b0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
